// File: rtl/maze_solver_sched.sv
`timescale 1ns/1ps
// maze_solver_sched: two-port round-robin scheduler in front of a shared 15x15 maze solver.
// The granted requester streams CELLS maze bits through to the solver. Path steps or the
// maze-not-valid verdict are routed back to the owner, and a done pulse closes each job.
// Ports: req/gnt arbitration; src_valid/src_maze maze input per requester; slv_* solver side;
// res_valid/res_x/res_y/res_not_valid/done per-requester results; timeout watchdog pulse.
// Optional watchdog: define MAZE_SCHED_WATCHDOG_EN to abort a solver silent for TIMEOUT cycles.
module maze_solver_sched #(
  parameter int CELLS   = 225,
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  input  logic [1:0] src_valid,
  input  logic [1:0] src_maze,
  output logic       slv_in_valid,
  output logic       slv_maze,
  input  logic       slv_out_valid,
  input  logic       slv_not_valid,
  input  logic [3:0] slv_x,
  input  logic [3:0] slv_y,
  output logic       slv_abort,
  output logic [1:0] res_valid,
  output logic [3:0] res_x,
  output logic [3:0] res_y,
  output logic [1:0] res_not_valid,
  output logic [1:0] done,
  output logic       timeout
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, STREAM, DONE} state_t;

  localparam logic [7:0] CELLS_W = CELLS[7:0];

  state_t     state;
  logic       owner;
  logic       rr;
  logic [7:0] bit_cnt;
  logic       pick;
  logic [1:0] owner_oh;

  // With both requesting, the rr pointer decides; a lone requester always wins.
  always_comb begin
    pick = rr;
    if (req == 2'b01) pick = 1'b0;
    else if (req == 2'b10) pick = 1'b1;
  end

  assign owner_oh = owner ? 2'b10 : 2'b01;

`ifdef MAZE_SCHED_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  logic [WDW-1:0] wd_cnt;
`else
  assign slv_abort = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= 1'b0;
      rr            <= 1'b0;
      bit_cnt       <= 8'd0;
      gnt           <= 2'b00;
      slv_in_valid  <= 1'b0;
      slv_maze      <= 1'b0;
      res_valid     <= 2'b00;
      res_x         <= 4'd0;
      res_y         <= 4'd0;
      res_not_valid <= 2'b00;
      done          <= 2'b00;
`ifdef MAZE_SCHED_WATCHDOG_EN
      wd_cnt        <= '0;
      slv_abort     <= 1'b0;
      timeout       <= 1'b0;
`endif
    end else begin
      // Pulse-style outputs default low each cycle; res_x/res_y hold.
      slv_in_valid  <= 1'b0;
      slv_maze      <= 1'b0;
      res_valid     <= 2'b00;
      res_not_valid <= 2'b00;
      done          <= 2'b00;
`ifdef MAZE_SCHED_WATCHDOG_EN
      slv_abort     <= 1'b0;
      timeout       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            owner   <= pick;
            gnt     <= pick ? 2'b10 : 2'b01;
            bit_cnt <= 8'd0;
            state   <= LOAD;
          end
        end

        LOAD: begin
          slv_in_valid <= src_valid[owner];
          slv_maze     <= src_maze[owner];
          // The counter reaching CELLS moves us to WAIT on the following edge.
          if (bit_cnt == CELLS_W) begin
            state <= WAIT;
`ifdef MAZE_SCHED_WATCHDOG_EN
            wd_cnt <= '0;
`endif
          end else if (src_valid[owner]) begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end

        WAIT: begin
          // A not-valid verdict outranks a path step; either outranks the watchdog.
          if (slv_not_valid) begin
            res_not_valid <= owner_oh;
            gnt           <= 2'b00;
            done          <= owner_oh;
            rr            <= ~owner;
            state         <= DONE;
          end else if (slv_out_valid) begin
            res_valid <= owner_oh;
            res_x     <= slv_x;
            res_y     <= slv_y;
            state     <= STREAM;
          end
`ifdef MAZE_SCHED_WATCHDOG_EN
          else if (wd_cnt == WD_LAST) begin
            slv_abort <= 1'b1;
            timeout   <= 1'b1;
            gnt       <= 2'b00;
            done      <= owner_oh;
            rr        <= ~owner;
            state     <= DONE;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
`endif
        end

        STREAM: begin
          if (slv_out_valid) begin
            res_valid <= owner_oh;
            res_x     <= slv_x;
            res_y     <= slv_y;
          end else begin
            gnt   <= 2'b00;
            done  <= owner_oh;
            rr    <= ~owner;
            state <= DONE;
          end
        end

        // gnt was dropped and done pulsed on entry, so DONE and the following
        // IDLE cycle form the two grant-free cycles between jobs.
        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
